// File: rtl/hyperram_rd_capture.sv
// HyperRAM read capture: registers the DDR input cell outputs, qualifies beats by RWDS, counts the burst, and buffers words in an FWFT FIFO.
// Define HYPERRAM_RD_BYTESWAP_EN to place the falling-edge byte in the high half of each word.
module hyperram_rd_capture #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       dq_ris,
    input  logic [7:0]       dq_fal,
    input  logic             rwds_ris,
    input  logic             rwds_fal,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic             overflow,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_overflow;
    logic               w_ovf_next;
    logic               w_tmo_hit;
    logic               w_push;

    logic [7:0]         r_dq_ris;
    logic [7:0]         r_dq_fal;
    logic               r_rwds_ris;
    logic               r_rwds_fal;
    logic               w_beat;
    logic [15:0]        w_word;

    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq_ris   <= '0;
            r_dq_fal   <= '0;
            r_rwds_ris <= 1'b0;
            r_rwds_fal <= 1'b0;
        end else begin
            r_dq_ris   <= dq_ris;
            r_dq_fal   <= dq_fal;
            r_rwds_ris <= rwds_ris;
            r_rwds_fal <= rwds_fal;
        end
    end

    // A beat needs a full RWDS pulse inside the clock period: high on rise, low on fall.
    assign w_beat = r_rwds_ris & ~r_rwds_fal;

`ifdef HYPERRAM_RD_BYTESWAP_EN
    assign w_word = {r_dq_fal, r_dq_ris};
`else
    assign w_word = {r_dq_ris, r_dq_fal};
`endif

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop     = ~w_empty & rd_ready;
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_tmo_next   = r_tmo;
        w_done_next  = 1'b0;
        w_ovf_next   = r_overflow;
        w_tmo_hit    = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ovf_next = 1'b0;
                    if (burst_len == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_cnt_next   = burst_len;
                        w_tmo_next   = '0;
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT, S_CAP: begin
                if (w_beat) begin
                    w_push     = 1'b1;
                    w_tmo_next = '0;
                    w_cnt_next = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_CAP;
                    end
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_tmo_hit    = 1'b1;
                    w_tmo_next   = '0;
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_tmo_next = r_tmo + TMO_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // A dropped word still counts toward the burst; only the sticky flag records it.
        if (w_push && w_full && !w_pop) begin
            w_ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_tmo      <= w_tmo_next;
            r_done     <= w_done_next;
            r_overflow <= w_ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
            end
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_word;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign timeout_err = w_tmo_hit;
    assign overflow    = r_overflow;
    assign rd_valid    = ~w_empty;
    assign rd_data     = w_empty ? 16'h0000 : r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: tb/tb_hyperram_rd_capture.sv
// Randomized and directed bench for hyperram_rd_capture against a queue-based burst model.
module tb_hyperram_rd_capture;

    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    dq_ris = '0;
    logic [7:0]    dq_fal = '0;
    logic          rwds_ris = 1'b0;
    logic          rwds_fal = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          rd_ready = 1'b0;
    logic          busy, done, timeout_err, overflow, rd_valid;
    logic [15:0]   rd_data;

    always #5 clk = ~clk;

    hyperram_rd_capture #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .dq_ris(dq_ris), .dq_fal(dq_fal),
        .rwds_ris(rwds_ris), .rwds_fal(rwds_fal), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .timeout_err(timeout_err), .overflow(overflow),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mkword(input logic [7:0] r, input logic [7:0] f);
`ifdef HYPERRAM_RD_BYTESWAP_EN
        return {f, r};
`else
        return {r, f};
`endif
    endfunction

    // Model: burst bookkeeping in plain integers, FIFO as a bounded queue.
    bit          m_active;
    int          m_rem, m_idle;
    logic [15:0] m_q[$];
    logic [15:0] m_pop_log[$];
    logic [15:0] dut_pop_log[$];
    bit          m_ovf, m_done;
    logic        m_prr, m_prf;
    logic [7:0]  m_pdr, m_pdf;
    logic        s_valid;
    logic [15:0] s_data;
    int          done_cnt = 0;
    int          tmo_cnt = 0;

    task automatic model_reset();
        m_active = 0; m_rem = 0; m_idle = 0; m_q.delete();
        m_ovf = 0; m_done = 0; m_prr = 0; m_prf = 0; m_pdr = 0; m_pdf = 0;
        s_valid = 0; s_data = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                bit pop, beat, push;
                logic [15:0] w;
                pop  = (m_q.size() > 0) && rd_ready;
                if (s_valid && rd_ready) dut_pop_log.push_back(s_data);
                beat = m_prr && !m_prf;
                w    = mkword(m_pdr, m_pdf);
                push = 0;
                m_done = 0;
                if (!m_active) begin
                    if (start) begin
                        m_ovf = 0;
                        if (burst_len == 0) m_done = 1;
                        else begin m_active = 1; m_rem = int'(burst_len); m_idle = 0; end
                    end
                end else if (beat) begin
                    push = 1; m_rem--; m_idle = 0;
                    if (m_rem == 0) begin m_active = 0; m_done = 1; end
                end else begin
                    m_idle++;
                    if (m_idle == TMO) m_active = 0;
                end
                if (pop) m_pop_log.push_back(m_q.pop_front());
                if (push) begin
                    if (m_q.size() < DEPTH) m_q.push_back(w);
                    else m_ovf = 1;
                end
                m_prr = rwds_ris; m_prf = rwds_fal; m_pdr = dq_ris; m_pdf = dq_fal;
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                logic e_tmo;
                e_tmo = m_active && (m_idle == TMO - 1) && !(m_prr && !m_prf);
                s_valid = rd_valid;
                s_data  = rd_data;
                if (done) done_cnt++;
                if (timeout_err) tmo_cnt++;
                chk("busy", 32'(busy), 32'(m_active));
                chk("done", 32'(done), 32'(m_done));
                chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
                if (m_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
            end
        end
    end

    task automatic drive(input logic rr, input logic rf, input logic [7:0] dr, input logic [7:0] df,
                         input logic st, input logic [CW-1:0] bl, input logic rdy);
        @(negedge clk);
        #1;
        rwds_ris = rr; rwds_fal = rf; dq_ris = dr; dq_fal = df;
        start = st; burst_len = bl; rd_ready = rdy;
    endtask

    task automatic beat(input logic [7:0] dr, input logic [7:0] df, input logic rdy);
        drive(1'b1, 1'b0, dr, df, 1'b0, '0, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, '0, rdy);
    endtask

    task automatic go(input logic [CW-1:0] bl, input logic rdy);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, bl, rdy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, t0, lat;
        logic [7:0] a, b;
        logic [15:0] exp_w;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_timeout", 32'(timeout_err), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Test 1: four-word burst, literal words.
        d0 = done_cnt; dut_pop_log.delete(); m_pop_log.delete();
        go(4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a = 8'hA0 + 8'(i); b = 8'h50 + 8'(i);
            beat(a, b, 1'b1);
        end
        idle(6, 1'b1);
        chk("t1_pop_count", 32'(dut_pop_log.size()), 4);
        for (int i = 0; i < 4; i++) begin
            a = 8'hA0 + 8'(i); b = 8'h50 + 8'(i);
`ifdef HYPERRAM_RD_BYTESWAP_EN
            exp_w = {b, a};
`else
            exp_w = {a, b};
`endif
            if (i < dut_pop_log.size()) chk("t1_dut_word", 32'(dut_pop_log[i]), 32'(exp_w));
            if (i < m_pop_log.size()) chk("t1_model_word", 32'(m_pop_log[i]), 32'(exp_w));
        end
        chk("t1_done_pulses", 32'(done_cnt - d0), 1);
        chk("t1_busy_low", 32'(busy), 0);

        // Test 2: beats separated by two idle RWDS cycles.
        d0 = done_cnt; t0 = tmo_cnt; dut_pop_log.delete();
        go(3, 1'b1);
        beat(8'h11, 8'h22, 1'b1); idle(2, 1'b1);
        beat(8'h33, 8'h44, 1'b1); idle(2, 1'b1);
        beat(8'h55, 8'h66, 1'b1); idle(6, 1'b1);
        chk("t2_pop_count", 32'(dut_pop_log.size()), 3);
        chk("t2_done_pulses", 32'(done_cnt - d0), 1);
        chk("t2_no_timeout", 32'(tmo_cnt - t0), 0);

        // Test 3: overflow with consumer stalled, then drain.
        d0 = done_cnt;
        go(10, 1'b0);
        for (int i = 0; i < 10; i++) beat(8'h10 + 8'(i), 8'h20 + 8'(i), 1'b0);
        idle(3, 1'b0);
        chk("t3_rd_valid", 32'(rd_valid), 1);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_done_pulses", 32'(done_cnt - d0), 1);
        dut_pop_log.delete();
        idle(12, 1'b1);
        chk("t3_drain_count", 32'(dut_pop_log.size()), 8);
        for (int i = 0; i < 8 && i < dut_pop_log.size(); i++)
            chk("t3_drain_word", 32'(dut_pop_log[i]), 32'(mkword(8'h10 + 8'(i), 8'h20 + 8'(i))));
        chk("t3_overflow_sticky", 32'(overflow), 1);

        // Test 4: burst aborted by timeout after two beats.
        d0 = done_cnt; t0 = tmo_cnt; dut_pop_log.delete();
        go(5, 1'b1);
        beat(8'hC1, 8'hD1, 1'b1);
        chk("t4_overflow_cleared", 32'(overflow), 0);
        beat(8'hC2, 8'hD2, 1'b1);
        lat = 0;
        for (int i = 0; i < 4 * TMO; i++) begin
            idle(1, 1'b1);
            lat++;
            if (timeout_err) break;
        end
        // One input-register cycle, then TIMEOUT cycles without a qualified beat.
        chk("t4_timeout_latency", 32'(lat), 32'(TMO + 1));
        idle(4, 1'b1);
        chk("t4_pop_count", 32'(dut_pop_log.size()), 2);
        chk("t4_no_done", 32'(done_cnt - d0), 0);
        chk("t4_timeout_pulses", 32'(tmo_cnt - t0), 1);

        // Test 5: zero-length burst, then start while busy.
        d0 = done_cnt;
        go(0, 1'b1);
        idle(1, 1'b1);
        chk("t5_done_next", 32'(done), 1);
        chk("t5_busy_never", 32'(busy), 0);
        idle(2, 1'b1);
        chk("t5_done_once", 32'(done_cnt - d0), 1);
        d0 = done_cnt; dut_pop_log.delete();
        go(2, 1'b1);
        beat(8'hE1, 8'hF1, 1'b1);
        go(7, 1'b1);
        beat(8'hE2, 8'hF2, 1'b1);
        idle(5, 1'b1);
        chk("t5_ignored_start_done", 32'(done_cnt - d0), 1);
        chk("t5_ignored_start_busy", 32'(busy), 0);
        chk("t5_ignored_start_pops", 32'(dut_pop_log.size()), 2);

        // Reset in the middle of a burst.
        go(6, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'h70 + 8'(i), 8'h80 + 8'(i), 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rd_valid", 32'(rd_valid), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        idle(2, 1'b1);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            logic st, rdy, rr, rf;
            logic [CW-1:0] bl;
            int r;
            st  = ($urandom_range(0, 15) == 0);
            bl  = CW'($urandom_range(0, 12));
            rdy = ($urandom_range(0, 9) < 7);
            r   = $urandom_range(0, 99);
            if (r < 60) begin
                rr = 1'b1; rf = 1'b0;
            end else if (r < 97) begin
                case ($urandom_range(0, 2))
                    0: begin rr = 1'b0; rf = 1'b0; end
                    1: begin rr = 1'b1; rf = 1'b1; end
                    default: begin rr = 1'b0; rf = 1'b1; end
                endcase
            end else begin
                idle(TMO + 4, rdy);
                rr = 1'b0; rf = 1'b0;
            end
            drive(rr, rf, 8'($urandom), 8'($urandom), st, bl, rdy);
        end
        idle(20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
